// File: rtl/param_regfile.sv
// Parameterised multi-ported register file with byte-enable writes, an optional
// hardwired zero register, optional write-to-read bypass and a sequential clear
// sweep that walks every register once while Busy is high.
module param_regfile #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned ADDRW    = 5,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 0
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic [WIDTH-1:0]   WriteData,
  input  logic [ADDRW-1:0]   WriteRegister,
  input  logic               RegWrite,
  input  logic [WIDTH/8-1:0] ByteEn,
  input  logic [ADDRW-1:0]   ReadRegister1,
  input  logic [ADDRW-1:0]   ReadRegister2,
  input  logic               Clear,
  output logic [WIDTH-1:0]   ReadData1,
  output logic [WIDTH-1:0]   ReadData2,
  output logic               Busy
);

  localparam int unsigned      NBYTES   = WIDTH / 8;
  localparam logic [ADDRW:0]   DEPTH_W  = (ADDRW+1)'(DEPTH);
  localparam logic [ADDRW-1:0] LAST_IDX = ADDRW'(DEPTH - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [ADDRW-1:0] r_index;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic             w_busy;
  logic             w_last;
  logic             w_wr_en;
  logic [WIDTH-1:0] w_wr_old;
  logic [WIDTH-1:0] w_merged;
  logic             w_rd1_valid;
  logic             w_rd2_valid;

  // Address lies inside the implemented register range
  function automatic logic in_range(input logic [ADDRW-1:0] a);
    return ({1'b0, a} < DEPTH_W);
  endfunction

  // Address hits the hardwired zero register
  function automatic logic is_zero_reg(input logic [ADDRW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Clear FSM state register
  always_ff @(posedge Clk) begin
    if (!Reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Clear FSM next-state: Clear is only honoured from IDLE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (Clear)  w_state_nxt = ST_SWEEP;
      ST_SWEEP: if (w_last) w_state_nxt = ST_IDLE;
      default:              w_state_nxt = ST_IDLE;
    endcase
  end

  // Clear FSM outputs
  always_comb begin
    w_busy = (r_state == ST_SWEEP);
    w_last = w_busy && (r_index == LAST_IDX);
  end

  assign Busy = w_busy;

  // Sweep index: loads zero on entry, advances once per sweep cycle
  always_ff @(posedge Clk) begin
    if (!Reset_n)                         r_index <= '0;
    else if (w_busy)                      r_index <= w_last ? '0 : r_index + ADDRW'(1);
    else if (Clear)                       r_index <= '0;
  end

  // Write qualification: no writes while sweeping, out of range, or to the zero register
  always_comb begin
    w_wr_en = RegWrite && !w_busy && in_range(WriteRegister) && !is_zero_reg(WriteRegister);
  end

  // Current contents of the write target, used for byte merging
  always_comb begin
    w_wr_old = '0;
    if (in_range(WriteRegister)) w_wr_old = r_mem[WriteRegister];
  end

  // Byte-merged post-write value of the write target
  always_comb begin
    w_merged = w_wr_old;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if (ByteEn[i]) w_merged[8*i +: 8] = WriteData[8*i +: 8];
    end
  end

  // Register storage: reset, sweep clearing, then qualified writes
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else if (w_busy) begin
      r_mem[r_index] <= '0;
    end else if (w_wr_en) begin
      r_mem[WriteRegister] <= w_merged;
    end
  end

  // Read address validity, shared by both ports
  always_comb begin
    w_rd1_valid = in_range(ReadRegister1) && !is_zero_reg(ReadRegister1);
    w_rd2_valid = in_range(ReadRegister2) && !is_zero_reg(ReadRegister2);
  end

  // Read port 1, with optional bypass of the in-flight write
  always_comb begin
    ReadData1 = '0;
    if (w_rd1_valid) begin
      if ((BYPASS != 0) && w_wr_en && (ReadRegister1 == WriteRegister)) ReadData1 = w_merged;
      else                                                             ReadData1 = r_mem[ReadRegister1];
    end
  end

  // Read port 2, with optional bypass of the in-flight write
  always_comb begin
    ReadData2 = '0;
    if (w_rd2_valid) begin
      if ((BYPASS != 0) && w_wr_en && (ReadRegister2 == WriteRegister)) ReadData2 = w_merged;
      else                                                             ReadData2 = r_mem[ReadRegister2];
    end
  end

endmodule

// File: tb/tb_param_regfile.sv
// Bench for param_regfile: a 32x32 pair (no bypass / bypass) tracked by an
// array-based reference model every cycle, plus two 16-bit instances for
// out-of-range addressing, non-zero r0 and sweep length.
module tb_param_regfile;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- main 32x32 pair ----------------
  logic        rst_n = 1'b0, we = 1'b0, clr = 1'b0;
  logic [31:0] wd = '0;
  logic [4:0]  wa = '0, ra1 = '0, ra2 = '0;
  logic [3:0]  be = '0;
  logic [31:0] a_rd1, a_rd2, b_rd1, b_rd2;
  logic        a_busy, b_busy;

  param_regfile #(.WIDTH(32), .DEPTH(32), .ADDRW(5), .ZERO_REG(1), .BYPASS(0)) u_a (
    .Clk(clk), .Reset_n(rst_n), .WriteData(wd), .WriteRegister(wa), .RegWrite(we),
    .ByteEn(be), .ReadRegister1(ra1), .ReadRegister2(ra2), .Clear(clr),
    .ReadData1(a_rd1), .ReadData2(a_rd2), .Busy(a_busy));

  param_regfile #(.WIDTH(32), .DEPTH(32), .ADDRW(5), .ZERO_REG(1), .BYPASS(1)) u_b (
    .Clk(clk), .Reset_n(rst_n), .WriteData(wd), .WriteRegister(wa), .RegWrite(we),
    .ByteEn(be), .ReadRegister1(ra1), .ReadRegister2(ra2), .Clear(clr),
    .ReadData1(b_rd1), .ReadData2(b_rd2), .Busy(b_busy));

  // ---------------- small 16-bit instances ----------------
  logic        s_rst_n = 1'b0, s_we = 1'b0, s_clr = 1'b0;
  logic [15:0] s_wd = '0;
  logic [3:0]  s_wa = '0, s_ra1 = '0, s_ra2 = '0;
  logic [1:0]  s_be = '0;
  logic [15:0] s8_rd1, s8_rd2, s9_rd1, s9_rd2;
  logic        s8_busy, s9_busy;

  param_regfile #(.WIDTH(16), .DEPTH(8), .ADDRW(3), .ZERO_REG(1), .BYPASS(0)) u_s8 (
    .Clk(clk), .Reset_n(s_rst_n), .WriteData(s_wd), .WriteRegister(s_wa[2:0]), .RegWrite(s_we),
    .ByteEn(s_be), .ReadRegister1(s_ra1[2:0]), .ReadRegister2(s_ra2[2:0]), .Clear(s_clr),
    .ReadData1(s8_rd1), .ReadData2(s8_rd2), .Busy(s8_busy));

  param_regfile #(.WIDTH(16), .DEPTH(9), .ADDRW(4), .ZERO_REG(0), .BYPASS(1)) u_s9 (
    .Clk(clk), .Reset_n(s_rst_n), .WriteData(s_wd), .WriteRegister(s_wa), .RegWrite(s_we),
    .ByteEn(s_be), .ReadRegister1(s_ra1), .ReadRegister2(s_ra2), .Clear(s_clr),
    .ReadData1(s9_rd1), .ReadData2(s9_rd2), .Busy(s9_busy));

  // ---------------- reference model for the 32x32 pair ----------------
  logic [31:0] m_mem [32];
  bit          m_busy  = 1'b0;
  int          m_idx   = 0;
  bit          m_valid = 1'b0;

  function automatic bit m_wr_ok();
    return we && !m_busy && (wa != 5'd0);
  endfunction

  function automatic logic [31:0] m_merge();
    logic [31:0] v;
    v = m_mem[wa];
    for (int i = 0; i < 4; i++) if (be[i]) v[8*i +: 8] = wd[8*i +: 8];
    return v;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] ad, input bit byp);
    if (ad == 5'd0) return 32'd0;
    if (byp && m_wr_ok() && ad == wa) return m_merge();
    return m_mem[ad];
  endfunction

  task automatic m_edge();
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_mem[i] = 32'd0;
      m_busy  = 1'b0;
      m_idx   = 0;
      m_valid = 1'b1;
    end else if (m_busy) begin
      m_mem[m_idx] = 32'd0;
      m_idx++;
      if (m_idx == 32) m_busy = 1'b0;
    end else begin
      if (m_wr_ok()) m_mem[wa] = m_merge();
      if (clr) begin
        m_busy = 1'b1;
        m_idx  = 0;
      end
    end
  endtask

  // One clock: compare both main instances against the model mid-cycle, then advance
  task automatic step();
    @(negedge clk);
    if (m_valid) begin
      chk("a_busy", 32'(a_busy), 32'(m_busy));
      chk("b_busy", 32'(b_busy), 32'(m_busy));
      chk("a_rd1", a_rd1, m_read(ra1, 1'b0));
      chk("a_rd2", a_rd2, m_read(ra2, 1'b0));
      chk("b_rd1", b_rd1, m_read(ra1, 1'b1));
      chk("b_rd2", b_rd2, m_read(ra2, 1'b1));
    end
    @(posedge clk);
    m_edge();
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] b);
    we = 1'b1; wa = a; wd = d; be = b;
    step();
    we = 1'b0;
  endtask

  task automatic s_tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, c8, c9;

    // reset
    rst_n = 1'b0;
    step();
    step();
    chk("rst_busy", 32'(a_busy), 32'd0);
    rst_n = 1'b1;

    // full word write, neighbouring register stays zero
    ra1 = 5'd2; ra2 = 5'd3;
    wr(5'd2, 32'hDEADBEEF, 4'hF);
    #1;
    chk("r2_full", a_rd1, 32'hDEADBEEF);
    chk("r3_zero", a_rd2, 32'd0);

    // partial byte write, disabled write
    wr(5'd2, 32'h11223344, 4'b0101);
    #1;
    chk("r2_bytes", a_rd1, 32'hDE22BE44);
    we = 1'b0; wa = 5'd5; wd = 32'h12345678; be = 4'hF;
    step();
    ra1 = 5'd5;
    #1;
    chk("r5_nowe", a_rd1, 32'd0);

    // zero register
    wr(5'd0, 32'd15, 4'hF);
    ra1 = 5'd0; ra2 = 5'd0;
    #1;
    chk("r0_p1", a_rd1, 32'd0);
    chk("r0_p2", a_rd2, 32'd0);
    wr(5'd11, 32'd15, 4'hF);
    ra2 = 5'd11;
    #1;
    chk("r0_vs", a_rd1, 32'd0);
    chk("r11", a_rd2, 32'd15);

    // bypass vs no bypass
    wr(5'd7, 32'd1, 4'hF);
    we = 1'b1; wa = 5'd7; wd = 32'd9; be = 4'hF; ra1 = 5'd7; ra2 = 5'd7;
    #1;
    chk("byp_new", b_rd1, 32'd9);
    chk("nobyp_old", a_rd1, 32'd1);
    step();
    we = 1'b0;
    #1;
    chk("nobyp_after", a_rd1, 32'd9);
    chk("byp_after", b_rd2, 32'd9);

    // fill, sweep, dropped write during sweep
    for (int i = 1; i < 32; i++) wr(5'(i), $urandom | 32'h1, 4'hF);
    clr = 1'b1;
    step();
    clr = 1'b0;
    cnt = 0;
    while (a_busy && cnt < 100) begin
      if (cnt == 3) begin we = 1'b1; wa = 5'd4; wd = 32'hAA; be = 4'hF; end
      else we = 1'b0;
      ra1 = 5'($urandom); ra2 = 5'd31;
      step();
      cnt++;
    end
    we = 1'b0;
    chk("sweep_len32", 32'(cnt), 32'd32);
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i);
      #1;
      chk("swept_zero", a_rd1, 32'd0);
    end

    // write and clear in the same idle cycle: write lands, then gets swept
    we = 1'b1; wa = 5'd20; wd = 32'hCAFEF00D; be = 4'hF; clr = 1'b1; ra1 = 5'd20;
    step();
    we = 1'b0; clr = 1'b0;
    #1;
    chk("wc_value", a_rd1, 32'hCAFEF00D);
    chk("wc_busy", 32'(a_busy), 32'd1);
    for (int i = 0; i < 40; i++) step();
    chk("wc_swept", a_rd1, 32'd0);

    // reset mid-sweep
    for (int i = 1; i < 32; i++) wr(5'(i), $urandom | 32'h100, 4'hF);
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int i = 0; i < 10; i++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    chk("abort_busy", 32'(a_busy), 32'd0);
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i);
      #1;
      chk("abort_zero", a_rd1, 32'd0);
    end

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      rst_n = ($urandom_range(0, 249) != 0);
      we    = 1'($urandom);
      wa    = 5'($urandom);
      wd    = $urandom;
      be    = 4'($urandom);
      clr   = ($urandom_range(0, 39) == 0);
      ra1   = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom);
      ra2   = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom);
      step();
    end
    rst_n = 1'b1; we = 1'b0; clr = 1'b0;

    // small instances
    s_rst_n = 1'b0;
    s_tick();
    s_rst_n = 1'b1;
    s_we = 1'b1; s_wa = 4'd9; s_wd = 16'h1234; s_be = 2'b11; s_ra1 = 4'd9;
    #1;
    chk("s9_oor_rd_pre", 32'(s9_rd1), 32'd0);
    s_tick();
    s_we = 1'b0; s_wa = 4'd0;
    #1;
    chk("s9_oor_rd", 32'(s9_rd1), 32'd0);
    s_we = 1'b1; s_wa = 4'd0; s_wd = 16'hBEEF; s_be = 2'b11; s_ra2 = 4'd0;
    s_tick();
    s_we = 1'b0;
    #1;
    chk("s9_r0_live", 32'(s9_rd2), 32'hBEEF);
    s_we = 1'b1; s_wa = 4'd8; s_wd = 16'hABCD; s_be = 2'b01; s_ra1 = 4'd8;
    #1;
    chk("s9_byp_merge", 32'(s9_rd1), 32'h00CD);
    s_tick();
    s_we = 1'b0;
    s_clr = 1'b1;
    s_tick();
    s_clr = 1'b0;
    c8 = 0; c9 = 0;
    for (int i = 0; i < 50; i++) begin
      if (s8_busy) c8++;
      if (s9_busy) c9++;
      if (!s8_busy && !s9_busy) break;
      s_tick();
    end
    chk("s8_sweep_len", 32'(c8), 32'd8);
    chk("s9_sweep_len", 32'(c9), 32'd9);
    s_ra1 = 4'd0; s_ra2 = 4'd8;
    #1;
    chk("s9_r0_swept", 32'(s9_rd1), 32'd0);
    chk("s9_r8_swept", 32'(s9_rd2), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
